// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: nibble width
// and controller state encoding.
package cla_pkg;

    localparam int CLA_NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } cla_seq_state_t;

endpackage

// File: rtl/cla4_cin.sv
// Combinational 4-bit carry-lookahead slice with carry-in.
// Each carry is g | p & previous carry, and each sum bit is p ^ the carry into that bit.
module cla4_cin
    import cla_pkg::*;
(
    input  logic [CLA_NIB_W-1:0] a,
    input  logic [CLA_NIB_W-1:0] b,
    input  logic                 cin,
    output logic [CLA_NIB_W-1:0] sum,
    output logic                 cout
);

    logic [CLA_NIB_W-1:0] g;
    logic [CLA_NIB_W-1:0] p;
    logic [CLA_NIB_W:0]   c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CLA_NIB_W; gi++) begin : g_bit
            assign g[gi]   = a[gi] & b[gi];
            assign p[gi]   = a[gi] ^ b[gi];
            assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign cout = c[CLA_NIB_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequencer that reuses one 4-bit CLA slice to add WIDTH-bit operands,
// one nibble per cycle LSB first, with a registered carry between nibbles.
// Optional subtract mode: define CLA_SEQ_ADDER_SUB_EN to add the in_sub port
// (B inverted per nibble, initial carry 1, out_carry=1 means no borrow).
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef CLA_SEQ_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    localparam int NIB   = WIDTH / CLA_NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    cla_seq_state_t state_reg;
    cla_seq_state_t state_next;

    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic                 carry_reg;
    logic                 out_valid_reg;
    logic                 out_carry_reg;
    logic [CLA_NIB_W-1:0] sum_nib_reg [NIB];

    logic [CLA_NIB_W-1:0] a_nibs [NIB];
    logic [CLA_NIB_W-1:0] b_nibs [NIB];
    logic [CLA_NIB_W-1:0] slice_a;
    logic [CLA_NIB_W-1:0] slice_b;
    logic [CLA_NIB_W-1:0] slice_sum;
    logic                 slice_cout;
    logic                 last_nib;
    logic                 start_carry;

    assign last_nib = (idx_reg == IDX_W'(NIB - 1));

`ifdef CLA_SEQ_ADDER_SUB_EN
    logic sub_reg;
    // Subtraction is A + ~B + 1, so the first carry-in supplies the +1.
    assign start_carry = in_sub;
    assign slice_b     = sub_reg ? ~b_nibs[idx_reg] : b_nibs[idx_reg];
`else
    assign start_carry = 1'b0;
    assign slice_b     = b_nibs[idx_reg];
`endif

    assign slice_a = a_nibs[idx_reg];

    // Split latched operands into nibbles and reassemble the result nibbles.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[gi*CLA_NIB_W +: CLA_NIB_W];
            assign b_nibs[gi] = b_reg[gi*CLA_NIB_W +: CLA_NIB_W];
            assign out_sum[gi*CLA_NIB_W +: CLA_NIB_W] = sum_nib_reg[gi];

            // Capture this nibble of the result in the RUN cycle that addresses it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_nib_reg[gi] <= '0;
                end else if (state_reg == ST_RUN && idx_reg == IDX_W'(gi)) begin
                    sum_nib_reg[gi] <= slice_sum;
                end
            end
        end
    endgenerate

    cla4_cin u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, step through nibbles, wait for consumer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)   state_next = ST_RUN;
            ST_RUN:  if (last_nib)   state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy     = 1'b1;
            ST_DONE: busy     = 1'b1;
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Operand latch, nibble index, inter-nibble carry and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_carry_reg <= 1'b0;
`ifdef CLA_SEQ_ADDER_SUB_EN
            sub_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= start_carry;
                        idx_reg   <= '0;
`ifdef CLA_SEQ_ADDER_SUB_EN
                        sub_reg   <= in_sub;
`endif
                    end
                end
                ST_RUN: begin
                    carry_reg <= slice_cout;
                    idx_reg   <= idx_reg + IDX_W'(1);
                    if (last_nib) begin
                        out_carry_reg <= slice_cout;
                        out_valid_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_carry = out_carry_reg;

endmodule
